// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller and its
// environment (instruction memory, data memory, datapath, status).
//   master : the controller side (drives requests, strobes and status)
//   slave  : the environment side (drives run, instr and the acks)
interface multicycle_controller_if;
  logic       run;
  logic [7:0] instr;        // [7:4] opcode, [3:0] funct; valid with imem_ack
  logic       imem_req;
  logic       imem_ack;
  logic       dmem_ack;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       jump;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src;
  logic       mem_to_reg;
  logic [2:0] alu_op;       // 000 ADD, 001 SUB
  logic [2:0] state;
  logic [7:0] retire_cnt;
  logic       err_illegal;
  logic       err_timeout;

  modport master (
    input  run, instr, imem_ack, dmem_ack,
    output imem_req, mem_read, mem_write, ir_write, pc_write, jump,
           reg_write, reg_dst, alu_src, mem_to_reg, alu_op,
           state, retire_cnt, err_illegal, err_timeout
  );

  modport slave (
    output run, instr, imem_ack, dmem_ack,
    input  imem_req, mem_read, mem_write, ir_write, pc_write, jump,
           reg_write, reg_dst, alu_src, mem_to_reg, alu_op,
           state, retire_cnt, err_illegal, err_timeout
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB for
// R-type / LW / SW, with JMP completing in DECODE. Memory waits are bounded
// by MEM_TIMEOUT un-acked cycles; illegal opcodes and timeouts park the FSM
// in ERR until reset.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_controller_if.master (handshakes, strobes, status)
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15  // 1..15 un-acked wait cycles
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controller_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6,
    BAD    = 3'd7
  } state_t;

  localparam logic [3:0] OP_R   = 4'h0;
  localparam logic [3:0] OP_LW  = 4'h1;
  localparam logic [3:0] OP_SW  = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] TMO    = 4'(MEM_TIMEOUT);

  state_t     st, st_nxt;
  logic [3:0] opcode, funct;
  logic [3:0] wait_cnt, wait_nxt, wait_inc;
  logic [7:0] retire_cnt;
  logic       err_ill, err_tmo;
  logic       retire, set_ill, set_tmo;
  logic       ack, tmo;
  logic       is_r, is_lw, is_sw, is_jmp;

  assign is_r   = (opcode == OP_R);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_jmp = (opcode == OP_JMP);

  // Only one memory wait can be in progress, so one counter serves both.
  assign ack      = (st == FETCH) ? bus.imem_ack : bus.dmem_ack;
  assign wait_inc = wait_cnt + 4'd1;
  assign tmo      = !ack && (wait_inc == TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      opcode     <= '0;
      funct      <= '0;
      wait_cnt   <= '0;
      retire_cnt <= '0;
      err_ill    <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      st       <= st_nxt;
      wait_cnt <= wait_nxt;
      if (st == FETCH && bus.imem_ack) {opcode, funct} <= bus.instr;
      if (retire)  retire_cnt <= retire_cnt + 8'd1;
      if (set_ill) err_ill    <= 1'b1;
      if (set_tmo) err_tmo    <= 1'b1;
    end
  end

  always_comb begin
    st_nxt         = st;
    wait_nxt       = '0;
    retire         = 1'b0;
    set_ill        = 1'b0;
    set_tmo        = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.jump       = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_op     = 3'b000;
    unique case (st)
      IDLE: if (bus.run) st_nxt = FETCH;
      FETCH: begin
        bus.imem_req = 1'b1;
        // ir_write and the SW pc_write are qualified by the ack so the
        // strobe lands in the very cycle the memory accepts; everything
        // else depends only on state and the latched opcode/funct.
        bus.ir_write = bus.imem_ack;
        if (bus.imem_ack)  st_nxt = DECODE;
        else if (tmo)      begin st_nxt = ERR; set_tmo = 1'b1; end
        else               wait_nxt = wait_inc;
      end
      DECODE: begin
        if (is_r || is_lw || is_sw) st_nxt = EXEC;
        else if (is_jmp) begin
          bus.jump     = 1'b1;
          bus.pc_write = 1'b1;
          retire       = 1'b1;
          st_nxt       = bus.run ? FETCH : IDLE;
        end else begin
          st_nxt  = ERR;
          set_ill = 1'b1;
        end
      end
      EXEC: begin
        bus.alu_op  = (is_r && funct == 4'h1) ? 3'b001 : 3'b000;
        bus.alu_src = is_lw || is_sw;
        st_nxt      = is_r ? WB : MEM;
      end
      MEM: begin
        bus.mem_read  = is_lw;
        bus.mem_write = is_sw;
        bus.alu_src   = 1'b1;
        bus.pc_write  = is_sw && bus.dmem_ack;
        if (bus.dmem_ack) begin
          if (is_lw) st_nxt = WB;
          else begin
            retire = 1'b1;
            st_nxt = bus.run ? FETCH : IDLE;
          end
        end else if (tmo) begin
          st_nxt  = ERR;
          set_tmo = 1'b1;
        end else wait_nxt = wait_inc;
      end
      WB: begin
        bus.reg_write  = 1'b1;
        bus.pc_write   = 1'b1;
        bus.reg_dst    = is_r;
        bus.mem_to_reg = is_lw;
        bus.alu_src    = is_lw;
        retire         = 1'b1;
        st_nxt         = bus.run ? FETCH : IDLE;
      end
      ERR:     st_nxt = ERR;
      default: st_nxt = ERR;  // code 7 is never entered; recover into ERR
    endcase
  end

  assign bus.state       = st;
  assign bus.retire_cnt  = retire_cnt;
  assign bus.err_illegal = err_ill;
  assign bus.err_timeout = err_tmo;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized, cycle-accurate check of multicycle_controller. For every
// instruction the bench derives the expected per-cycle trace (state,
// strobes, retire count, error flags) directly from the instruction class
// and the ack delays it chose, then compares the DUT each cycle.
module tb_multicycle_controller;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if b ();
  multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  int n_chk = 0;
  int n_pass = 0;

  // model state
  logic [7:0] m_ret = '0;
  bit m_ill = 0, m_tmo = 0, m_idle = 1;

  logic [25:0] dv;
  assign dv = {b.state, b.retire_cnt, b.imem_req, b.ir_write, b.pc_write, b.jump,
               b.reg_write, b.reg_dst, b.alu_src, b.mem_to_reg, b.mem_read,
               b.mem_write, b.alu_op, b.err_illegal, b.err_timeout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [12:0] ov(bit ireq, bit irw, bit pcw, bit jmp, bit rw, bit rd,
                                     bit as_, bit m2r, bit mr, bit mw, logic [2:0] aop);
    return {ireq, irw, pcw, jmp, rw, rd, as_, m2r, mr, mw, aop};
  endfunction

  function automatic logic [25:0] ev(logic [2:0] st, logic [12:0] o);
    return {st, m_ret, o, m_ill, m_tmo};
  endfunction

  // Inputs are already set for this cycle (we sit just after a negedge).
  task automatic step(input string tag, input logic [25:0] e);
    #1 chk(tag, {6'd0, dv}, {6'd0, e});
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_ret = '0; m_ill = 0; m_tmo = 0; m_idle = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("reset", {6'd0, dv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic err_hold(input int n);
    for (int i = 0; i < n; i++) begin
      b.run = 1'($urandom); b.imem_ack = 1'($urandom); b.dmem_ack = 1'($urandom);
      step("err_hold", ev(3'd6, '0));
    end
  endtask

  task automatic complete(input bit run_after);
    m_ret  = m_ret + 8'd1;
    m_idle = !run_after;
  endtask

  // id/dd: ack delay in FETCH/MEM; rst_mem >= 0 pulses reset in that MEM cycle.
  task automatic run_instr(input logic [7:0] ins, input int id, input int dd,
                           input bit run_after, input int rst_mem);
    logic [3:0] op, fn;
    bit r, lw, sw;
    op = ins[7:4]; fn = ins[3:0];
    r = (op == 4'h0); lw = (op == 4'h1); sw = (op == 4'h2);
    b.imem_ack = 0; b.dmem_ack = 0;
    if (m_idle) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        b.run = 0; step("idle_hold", ev(3'd0, '0));
      end
      b.run = 1; step("idle_go", ev(3'd0, '0));
    end
    for (int k = 0; k <= id; k++) begin
      b.run = 1'($urandom);
      if (k == TMO) begin
        b.imem_ack = 0; m_tmo = 1;
        step("tmo_fetch", ev(3'd6, '0));
        return;
      end
      b.imem_ack = (k == id);
      b.instr = (k == id) ? ins : 8'($urandom);
      step("fetch", ev(3'd1, ov(1, k == id, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0)));
    end
    b.imem_ack = 0; b.instr = 8'($urandom); b.run = run_after;
    if (op == 4'h6) begin
      step("dec_jmp", ev(3'd2, ov(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3'd0)));
      complete(run_after);
      return;
    end
    step("decode", ev(3'd2, '0));
    if (!(r || lw || sw)) begin
      m_ill = 1;
      step("illegal", ev(3'd6, '0));
      return;
    end
    step("exec", ev(3'd3, ov(0, 0, 0, 0, 0, 0, lw || sw, 0, 0, 0,
                             (r && fn == 4'h1) ? 3'b001 : 3'b000)));
    if (!r) begin
      for (int k = 0; k <= dd; k++) begin
        if (k == TMO) begin
          b.dmem_ack = 0; m_tmo = 1;
          step("tmo_mem", ev(3'd6, '0));
          return;
        end
        b.dmem_ack = (k == dd);
        if (k == rst_mem) begin
          b.dmem_ack = 0;
          #1 chk("mem_pre_rst", {6'd0, dv},
                 {6'd0, ev(3'd4, ov(0, 0, 0, 0, 0, 0, 1, 0, lw, sw, 3'd0))});
          rst_n = 1'b0;
          #1 chk("rst_async", {6'd0, dv}, 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          model_clear();
          return;
        end
        step("mem", ev(3'd4, ov(0, 0, sw && k == dd, 0, 0, 0, 1, 0, lw, sw, 3'd0)));
      end
      b.dmem_ack = 0;
      if (sw) begin
        complete(run_after);
        return;
      end
    end
    step("wb", ev(3'd5, ov(0, 0, 1, 0, 1, r, lw, lw, 0, 0, 3'd0)));
    complete(run_after);
  endtask

  function automatic logic [7:0] rand_ins();
    logic [3:0] f;
    f = 4'($urandom);
    case ($urandom_range(0, 4))
      0:       return 8'h01;
      1:       return {4'h0, f};
      2:       return {4'h1, f};
      3:       return {4'h2, f};
      default: return {4'h6, f};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b.run = 0; b.instr = '0; b.imem_ack = 0; b.dmem_ack = 0;
    @(negedge clk);
    #1 chk("reset_state", {6'd0, dv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b.run = 0; b.imem_ack = 1'($urandom); step("idle_norun", ev(3'd0, '0));
    end

    run_instr(8'h01, 0, 0, 1, -1);   // SUB, immediate acks
    chk("retire_one", {24'd0, b.retire_cnt}, 32'd1);
    run_instr(8'h10, 0, 3, 1, -1);   // LW, dmem ack after 3 waits
    run_instr(8'h20, 1, 2, 1, -1);   // SW, back to FETCH
    run_instr(8'h60, 0, 0, 0, -1);   // JMP, then IDLE
    run_instr(8'h00, 14, 0, 1, -1);  // fetch ack on the 15th cycle

    for (int i = 0; i < 40; i++) begin
      int id, dd;
      id = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 4));
      dd = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 4));
      run_instr(rand_ins(), id, dd, 1'($urandom), -1);
    end

    do_reset();
    for (int i = 0; i < 256; i++) run_instr({4'h0, 4'($urandom)}, 0, 0, 1, -1);
    chk("retire_wrap", {24'd0, b.retire_cnt}, 32'd0);

    run_instr(8'h20, 0, 6, 1, 2);    // reset pulsed mid-MEM with mem_write high
    run_instr(8'h10, 0, 6, 1, 1);    // same with mem_read high

    run_instr(8'h60, 0, 0, 1, -1);
    run_instr(8'hF0, 0, 0, 1, -1);   // illegal
    err_hold(5);
    do_reset();

    run_instr(8'h00, 15, 0, 1, -1);  // imem never acks
    err_hold(4);
    do_reset();

    run_instr(8'h10, 0, 15, 1, -1);  // dmem never acks
    err_hold(4);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
